// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// mem_bus_arbiter_pkg : shared types and encodings for the CPU/IOP memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

  // Word address and data use big-endian bit numbering (bit 31 / bit 0 = LSB / MSB)
  typedef logic [15:31] addr_t;
  typedef logic [0:31]  data_t;
  typedef logic [0:3]   be_t;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_IOP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    MASTER_CPU = 1'b0,
    MASTER_IOP = 1'b1
  } master_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if : one master's request/grant/data bundle toward the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic  req;
  addr_t address;
  be_t   write_en;
  data_t wdata;
  logic  grant;
  logic  rvalid;
  data_t rdata;

  modport master (
    output req, address, write_en, wdata,
    input  grant, rvalid, rdata
  );

  modport slave (
    input  req, address, write_en, wdata,
    output grant, rvalid, rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter_hold_counter.sv
// ============================================================================
// arb_hold_counter : counts cycles the non-owning master has waited in a burst
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_hold_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hold_cnt <= '0;
    end else if (inc) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign at_max = (hold_cnt == HOLD_W'(BURST_MAX - 1));

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares synchronous-read main memory between CPU and IOP
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int IOP_PRIO  = 0
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.slave cpu,
  mem_bus_arbiter_if.slave iop,
  output addr_t            mem_address,
  output be_t              mem_write_en,
  output data_t            mem_data_in,
  input  data_t            mem_rdata,
  output logic             cpu_active
);

  arb_state_t state, state_nx;
  master_t    last_owner, last_owner_nx;
  logic       hold_clear, hold_inc, at_max;
  logic       cpu_issue, iop_issue;
  logic       cpu_rvalid_q, iop_rvalid_q;

  arb_hold_counter #(
    .BURST_MAX(BURST_MAX)
  ) u_hold (
    .clock (clock),
    .reset (reset),
    .clear (hold_clear),
    .inc   (hold_inc),
    .at_max(at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_owner <= MASTER_IOP;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
    end
  end

  // The waiting master takes over on the very next edge: no idle cycle between owners
  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    hold_clear    = 1'b1;
    hold_inc      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (cpu.req && iop.req) begin
          state_nx = ((IOP_PRIO != 0) || (last_owner == MASTER_CPU)) ? ARB_IOP : ARB_CPU;
        end else if (cpu.req) begin
          state_nx = ARB_CPU;
        end else if (iop.req) begin
          state_nx = ARB_IOP;
        end
      end
      ARB_CPU: begin
        if (iop.req) begin
          if (!cpu.req || at_max) begin
            state_nx      = ARB_IOP;
            last_owner_nx = MASTER_CPU;
          end else begin
            hold_clear = 1'b0;
            hold_inc   = 1'b1;
          end
        end else if (!cpu.req) begin
          state_nx      = ARB_IDLE;
          last_owner_nx = MASTER_CPU;
        end
      end
      ARB_IOP: begin
        if (cpu.req) begin
          if (!iop.req || at_max) begin
            state_nx      = ARB_CPU;
            last_owner_nx = MASTER_IOP;
          end else begin
            hold_clear = 1'b0;
            hold_inc   = 1'b1;
          end
        end else if (!iop.req) begin
          state_nx      = ARB_IDLE;
          last_owner_nx = MASTER_IOP;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Gating with reset keeps a stale owner from writing during the reset cycle
  assign cpu_issue = (state == ARB_CPU) && cpu.req && !reset;
  assign iop_issue = (state == ARB_IOP) && iop.req && !reset;

  always_comb begin
    mem_address  = '0;
    mem_write_en = '0;
    mem_data_in  = '0;
    if (cpu_issue) begin
      mem_address  = cpu.address;
      mem_write_en = cpu.write_en;
      mem_data_in  = cpu.wdata;
    end else if (iop_issue) begin
      mem_address  = iop.address;
      mem_write_en = iop.write_en;
      mem_data_in  = iop.wdata;
    end
  end

  // Read tag follows the issuer, not the current owner
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      iop_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_issue && (cpu.write_en == '0);
      iop_rvalid_q <= iop_issue && (iop.write_en == '0);
    end
  end

  assign cpu.grant  = (state == ARB_CPU);
  assign iop.grant  = (state == ARB_IOP);
  assign cpu.rvalid = cpu_rvalid_q;
  assign iop.rvalid = iop_rvalid_q;
  assign cpu.rdata  = mem_rdata;
  assign iop.rdata  = mem_rdata;
  assign cpu_active = (state == ARB_CPU);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : two arbiters (round-robin/16, IOP-priority/4) vs a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic  clock;
  logic  reset;
  logic  cpu_req, iop_req;
  addr_t cpu_addr, iop_addr;
  be_t   cpu_we, iop_we;
  data_t cpu_wd, iop_wd;

  int n_chk = 0;
  int n_fail = 0;

  mem_bus_arbiter_if cpu0_if ();
  mem_bus_arbiter_if iop0_if ();
  mem_bus_arbiter_if cpu1_if ();
  mem_bus_arbiter_if iop1_if ();

  assign cpu0_if.req = cpu_req;  assign cpu0_if.address = cpu_addr;
  assign cpu0_if.write_en = cpu_we; assign cpu0_if.wdata = cpu_wd;
  assign cpu1_if.req = cpu_req;  assign cpu1_if.address = cpu_addr;
  assign cpu1_if.write_en = cpu_we; assign cpu1_if.wdata = cpu_wd;
  assign iop0_if.req = iop_req;  assign iop0_if.address = iop_addr;
  assign iop0_if.write_en = iop_we; assign iop0_if.wdata = iop_wd;
  assign iop1_if.req = iop_req;  assign iop1_if.address = iop_addr;
  assign iop1_if.write_en = iop_we; assign iop1_if.wdata = iop_wd;

  addr_t ma [2];
  be_t   mwe [2];
  data_t md [2];
  data_t mrd [2];
  logic  act [2];

  mem_bus_arbiter #(.BURST_MAX(16), .IOP_PRIO(0)) dut0 (
    .clock(clock), .reset(reset), .cpu(cpu0_if), .iop(iop0_if),
    .mem_address(ma[0]), .mem_write_en(mwe[0]), .mem_data_in(md[0]),
    .mem_rdata(mrd[0]), .cpu_active(act[0])
  );

  mem_bus_arbiter #(.BURST_MAX(4), .IOP_PRIO(1)) dut1 (
    .clock(clock), .reset(reset), .cpu(cpu1_if), .iop(iop1_if),
    .mem_address(ma[1]), .mem_write_en(mwe[1]), .mem_data_in(md[1]),
    .mem_rdata(mrd[1]), .cpu_active(act[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural synchronous-read memories, one per arbiter
  logic [0:31] bmem [2][64];
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      mrd[k] <= bmem[k][ma[k][26:31]];
      for (int b = 0; b < 4; b++)
        if (mwe[k][b]) bmem[k][ma[k][26:31]][b*8 +: 8] <= md[k][b*8 +: 8];
    end
  end

  // Reference model: owner 0=none 1=CPU 2=IOP, waited = cycles the other master has waited
  int          bm [2]   = '{16, 4};
  int          prio [2] = '{0, 1};
  int          m_own [2];
  int          m_wait [2];
  int          m_last [2];
  logic        m_rvc [2];
  logic        m_rvi [2];
  data_t       m_rd [2];
  logic [0:31] shadow [2][64];

  function automatic int issuer(input int k);
    if (reset) return 0;
    if (m_own[k] == 1 && cpu_req) return 1;
    if (m_own[k] == 2 && iop_req) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_we(input int k);
    int w = issuer(k);
    return (w == 1) ? 32'(cpu_we) : (w == 2) ? 32'(iop_we) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_addr(input int k);
    int w = issuer(k);
    return (w == 1) ? 32'(cpu_addr) : (w == 2) ? 32'(iop_addr) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_data(input int k);
    int w = issuer(k);
    return (w == 1) ? cpu_wd : (w == 2) ? iop_wd : 32'd0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    int    w, other;
    logic  own_req, oth_req;
    be_t   we;
    addr_t a;
    data_t d;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_own[k] = 0; m_wait[k] = 0; m_last[k] = 2;
        m_rvc[k] = 1'b0; m_rvi[k] = 1'b0;
      end else begin
        w  = issuer(k);
        we = (w == 1) ? cpu_we   : (w == 2) ? iop_we   : '0;
        a  = (w == 1) ? cpu_addr : (w == 2) ? iop_addr : '0;
        d  = (w == 1) ? cpu_wd   : (w == 2) ? iop_wd   : '0;
        m_rvc[k] = (w == 1) && (we == '0);
        m_rvi[k] = (w == 2) && (we == '0);
        m_rd[k]  = shadow[k][a[26:31]];
        for (int b = 0; b < 4; b++)
          if (we[b]) shadow[k][a[26:31]][b*8 +: 8] = d[b*8 +: 8];
        if (m_own[k] == 0) begin
          if (cpu_req && iop_req) m_own[k] = (prio[k] != 0 || m_last[k] == 1) ? 2 : 1;
          else if (cpu_req)       m_own[k] = 1;
          else if (iop_req)       m_own[k] = 2;
        end else begin
          other   = 3 - m_own[k];
          own_req = (m_own[k] == 1) ? cpu_req : iop_req;
          oth_req = (other == 1) ? cpu_req : iop_req;
          if (oth_req) begin
            m_wait[k]++;
            if (!own_req || m_wait[k] >= bm[k]) begin
              m_last[k] = m_own[k]; m_own[k] = other; m_wait[k] = 0;
            end
          end else begin
            m_wait[k] = 0;
            if (!own_req) begin
              m_last[k] = m_own[k]; m_own[k] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mem_write_en", k, 32'(mwe[k]), exp_we(k));
      chk("mem_address",  k, 32'(ma[k]),  exp_addr(k));
      chk("mem_data_in",  k, md[k],       exp_data(k));
    end
    @(posedge clock);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("cpu_grant",  k, (k == 0) ? cpu0_if.grant  : cpu1_if.grant,  32'(m_own[k] == 1));
      chk("iop_grant",  k, (k == 0) ? iop0_if.grant  : iop1_if.grant,  32'(m_own[k] == 2));
      chk("cpu_active", k, act[k], 32'(m_own[k] == 1));
      chk("cpu_rvalid", k, (k == 0) ? cpu0_if.rvalid : cpu1_if.rvalid, 32'(m_rvc[k]));
      chk("iop_rvalid", k, (k == 0) ? iop0_if.rvalid : iop1_if.rvalid, 32'(m_rvi[k]));
      if (m_rvc[k]) chk("cpu_rdata", k, (k == 0) ? cpu0_if.rdata : cpu1_if.rdata, m_rd[k]);
      if (m_rvi[k]) chk("iop_rdata", k, (k == 0) ? iop0_if.rdata : iop1_if.rdata, m_rd[k]);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b1; cpu_addr = '0; cpu_we = '0; cpu_wd = '0;
    iop_req = 1'b0; iop_addr = '0; iop_we = '0; iop_wd = '0;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_wait[k] = 0; m_last[k] = 2; m_rvc[k] = 1'b0; m_rvi[k] = 1'b0; m_rd[k] = '0;
    end

    cyc(); cyc();
    chk("grant_in_reset", 0, cpu0_if.grant, 32'd0);
    reset = 1'b0;
    cyc();
    chk("cpu_grant_first", 0, cpu0_if.grant, 32'd1);
    chk("cpu_active_first", 0, act[0], 32'd1);
    chk("iop_grant_first", 0, iop0_if.grant, 32'd0);

    // Fill every word so later reads have known contents
    cpu_we = 4'hF;
    for (int i = 0; i < 64; i++) begin
      cpu_addr = addr_t'(i); cpu_wd = $urandom; cyc();
    end
    cpu_addr = 17'h20; cpu_wd = 32'h12345678; cyc();
    cpu_addr = 17'h21; cpu_wd = 32'hDEADBEEF; cyc();

    // IOP waits behind a CPU burst while trying to write 0x20 ungranted
    cpu_we = '0; cpu_addr = 17'h10;
    iop_req = 1'b1; iop_addr = 17'h20; iop_we = 4'hF; iop_wd = 32'hFFFFFFFF;
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("iop_still_waiting", 0, iop0_if.grant, 32'd0);
    end
    cpu_addr = 17'h21;
    cyc();
    chk("iop_grant_at_16", 0, iop0_if.grant, 32'd1);
    chk("cpu_grant_dropped", 0, cpu0_if.grant, 32'd0);
    chk("cpu_rvalid_last", 0, cpu0_if.rvalid, 32'd1);
    chk("iop_rvalid_last", 0, iop0_if.rvalid, 32'd0);
    chk("rdata_deadbeef", 0, cpu0_if.rdata, 32'hDEADBEEF);
    chk("word20_kept", 0, bmem[0][32], 32'h12345678);
    iop_we = '0;
    cyc();
    chk("iop_reads_20", 0, iop0_if.rdata, 32'h12345678);

    cpu_req = 1'b0; iop_req = 1'b0;
    cyc(); cyc();

    // Ties from idle: round-robin alternates, IOP priority always wins
    for (int r = 0; r < 3; r++) begin
      cpu_req = 1'b1; iop_req = 1'b1;
      cyc();
      chk("tie_cpu_grant", 0, cpu0_if.grant, 32'(r != 1));
      chk("tie_iop_grant", 0, iop0_if.grant, 32'(r == 1));
      chk("tie_prio_iop", 1, iop1_if.grant, 32'd1);
      cpu_req = 1'b0; iop_req = 1'b0;
      cyc(); cyc();
    end

    // Reset in the middle of an IOP write burst
    iop_req = 1'b1; iop_addr = 17'h30; iop_we = 4'hF; iop_wd = 32'hA5A5A5A5;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_cpu_grant", k, (k == 0) ? cpu0_if.grant : cpu1_if.grant, 32'd0);
      chk("rst_iop_grant", k, (k == 0) ? iop0_if.grant : iop1_if.grant, 32'd0);
      chk("rst_iop_rvalid", k, (k == 0) ? iop0_if.rvalid : iop1_if.rvalid, 32'd0);
      chk("rst_write_en", k, 32'(mwe[k]), 32'd0);
    end
    reset = 1'b0; cpu_req = 1'b1;
    cyc();
    chk("post_rst_tie_rr", 0, cpu0_if.grant, 32'd1);
    chk("post_rst_tie_prio", 1, iop1_if.grant, 32'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 3) == 0) iop_req = ~iop_req;
      cpu_addr = addr_t'($urandom_range(0, 63));
      iop_addr = addr_t'($urandom_range(0, 63));
      cpu_we   = ($urandom_range(0, 1) == 0) ? be_t'(4'h0) : be_t'($urandom_range(0, 15));
      iop_we   = ($urandom_range(0, 1) == 0) ? be_t'(4'h0) : be_t'($urandom_range(0, 15));
      cpu_wd   = $urandom;
      iop_wd   = $urandom;
      reset    = ($urandom_range(0, 79) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
